xbar_sched: RTL
===============

# xbar_sched

Crossbar connection scheduler for a 4-master × 4-slave crossbar. Each master raises a request with a 2-bit target-slave index. Each slave port runs its own round-robin arbitration and holds a connection until the owner signals completion or drops its request. Registered per-slave select outputs drive the crossbar mux, and per-master grants go back to the masters.

## Interface
Parameters:
- HOLD_MAX, default 16: maximum cycles a connection may be held while another master waits. Used only with hold limit compiled in. Legal range 2..255.
- CNT_W, default 8: hold counter width. Must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; asserting low clears all state immediately
- req  in  4  req[i]: master i requests its target slave
- dst  in  8  dst[2i+1:2i]: target slave of master i; sampled only at arbitration
- done  in  4  done[i]: one-cycle pulse, master i finishes its transfer
- gnt  out  4  gnt[i]: master i currently owns a slave port (registered)
- sel  out  8  sel[2j+1:2j]: master index routed to slave j (registered)
- sel_vld  out  4  sel_vld[j]: slave j connected
- busy  out  1  OR of sel_vld

## Operation
- Reset values: gnt=0, sel=0, sel_vld=0, busy=0, all round-robin pointers ptr[j]=0, all ports IDLE, all hold counters 0.
- Candidate set for port j: C_j = {i : req[i] & dst_i==j & ~gnt[i]}. A master holds at most one port.
- Each port j has a 2-state FSM: IDLE and BUSY.
- IDLE:
  - If C_j is non-empty, select the first i in cyclic order ptr[j], ptr[j]+1, … mod 4.
  - Next edge: BUSY, owner=i, sel[j]=i, sel_vld[j]=1, ptr[j]=(i+1) mod 4.
  - If C_j is empty, stay in IDLE.
- BUSY, release condition: done[owner] | ~req[owner].
  - On release, the port re-arbitrates in the same cycle over C_j, with the owner excluded.
  - If a winner exists, the next edge switches directly to the winner with no bubble cycle, and ptr updates as in IDLE.
  - Otherwise the next edge returns the port to IDLE with sel_vld[j]=0. sel holds its last value.
- gnt[i] = 1 iff some j has sel_vld[j] & sel[j]==i. gnt is computed from next state and registered, so it is never combinational from inputs.
- A change of dst while a master is granted is ignored until that master is released and re-arbitrates.
- Simultaneous done[i] and req[i] high: master i is released and is not eligible at that edge. It may win at a later edge.
- Different ports arbitrate independently. Masters targeting different slaves are granted in the same cycle.
- done for a non-granted master is ignored.

## Timing
- Request-to-grant latency: 1 cycle. req seen at edge N with port IDLE gives gnt and sel_vld high after edge N+1.
- Release latency: 1 cycle. done at edge N gives gnt low after edge N+1, with the new owner's gnt high in the same cycle if a candidate exists.
- Reset assertion clears outputs asynchronously. Deassertion takes effect at the next rising edge.

## Configuration
- XBAR_HOLD_LIMIT_EN defined:
  - Each port has a CNT_W-bit hold counter. It clears on every grant and increments each BUSY cycle, saturating.
  - When count==HOLD_MAX-1 and C_j (owner excluded) is non-empty, the owner is preempted at the next edge: treated as a release, the winner is granted, and the preempted master's gnt drops.
  - With no waiter, no preemption occurs and the counter saturates.
- XBAR_HOLD_LIMIT_EN undefined: no counters. The owner holds until done or dropped req. HOLD_MAX and CNT_W are unused.

## Structure
- Shared package xbar_pkg:
  - NUM_M=4, NUM_S=4, IDX_W=2
  - port state enum {IDLE, BUSY}
  - round-robin pick function (4-bit candidate vector plus pointer returns index and valid)
- Sub-module xbar_port_arb: one slave port's FSM, pointer, owner register and optional hold counter. Instantiated 4 times.
- xbar_sched top:
  - builds C_j from req, dst and registered gnt
  - ORs the owners into gnt
  - drives busy

## Test plan
- Reset: reset low mid-connection (sel_vld=4'b0011) -> all outputs 0 immediately. After release, M0 req dst=2 -> sel[5:4]=0, sel_vld=4'b0100, gnt=4'b0001 after 1 edge.
- Round robin: M0..M3 all req dst=1, each pulses done 3 cycles after grant -> grant order 0,1,2,3,0. Switch edges show no gap cycle on sel_vld[1].
- Parallel: M0→S3, M1→S2, M2→S1, M3→S0 same cycle -> gnt=4'b1111 and sel=8'b00_01_10_11 after 1 edge.
- Drop: granted M2 deasserts req with no done -> sel_vld low and gnt[2]=0 after 1 edge. Same-cycle done[2]&req[2] with M1 waiting -> M1 granted, M2 not.
- Hold limit (macro defined, HOLD_MAX=4): M0 holds S0, M1 waits -> M0 preempted after 4 BUSY cycles and M1 granted. With the macro undefined -> M0 holds until done.

Source files
------------

// File: rtl/xbar_pkg.sv
// xbar_pkg: shared sizes, port state encoding and the round-robin pick helper
// for the 4x4 crossbar connection scheduler.
package xbar_pkg;

  localparam int NUM_M = 4;
  localparam int NUM_S = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } port_state_e;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of cand in cyclic order ptr, ptr+1, ... (mod NUM_M).
  function automatic rr_pick_t rr_pick(input logic [NUM_M-1:0] cand,
                                       input logic [IDX_W-1:0] ptr);
    rr_pick_t         r;
    logic [IDX_W-1:0] i;
    r = '0;
    // Walk from the farthest offset down so the nearest candidate wins last.
    for (int k = NUM_M - 1; k >= 0; k--) begin
      i = ptr + IDX_W'(k);
      if (cand[i]) begin
        r.vld = 1'b1;
        r.idx = i;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/xbar_port_arb.sv
// xbar_port_arb: one slave port's IDLE/BUSY FSM, round-robin pointer, owner
// register and (with XBAR_HOLD_LIMIT_EN defined) a saturating hold counter
// that lets a waiting master preempt a long-held connection.
module xbar_port_arb
  import xbar_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NUM_M-1:0] cand_i,   // eligible masters, current owner already excluded
  input  logic [NUM_M-1:0] req_i,
  input  logic [NUM_M-1:0] done_i,
  output logic [IDX_W-1:0] sel_d_o,  // next-state owner, used to build registered gnt
  output logic             vld_d_o,
  output logic [IDX_W-1:0] sel_q_o,
  output logic             vld_q_o
);

  port_state_e      state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  rr_pick_t         pick;
  logic             rel;
  logic             take;
  logic             preempt;

  assign pick = rr_pick(cand_i, ptr_q);

`ifdef XBAR_HOLD_LIMIT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Preempt only when the hold limit is reached and somebody is waiting.
  assign preempt = (state_q == BUSY) && (cnt_q == CNT_W'(HOLD_MAX - 1)) && pick.vld;

  // Hold counter: clears on every grant, counts BUSY cycles and saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (take) begin
      cnt_d = '0;
    end else if ((state_q == BUSY) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign preempt = 1'b0;
`endif

  // Next-state logic: arbitrate when idle, or on release of the current owner.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    take    = 1'b0;
    rel     = done_i[owner_q] | ~req_i[owner_q] | preempt;
    case (state_q)
      IDLE: begin
        if (pick.vld) take = 1'b1;
      end
      BUSY: begin
        if (rel) begin
          if (pick.vld) take = 1'b1;
          else          state_d = IDLE;   // owner_q keeps the last select value
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      state_d = BUSY;
      owner_d = pick.idx;
      ptr_d   = pick.idx + IDX_W'(1);
    end
  end

  // State, owner and pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments and clears on the async reset edge.
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign sel_d_o = owner_d;
  assign vld_d_o = (state_d == BUSY);
  assign sel_q_o = owner_q;
  assign vld_q_o = (state_q == BUSY);

endmodule

// File: rtl/xbar_sched.sv
// xbar_sched: 4-master x 4-slave crossbar connection scheduler. Builds each
// port's candidate set, runs four independent round-robin port arbiters and
// registers the per-master grants. Optional feature: XBAR_HOLD_LIMIT_EN
// (hold-time preemption inside xbar_port_arb).
module xbar_sched
  import xbar_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_M-1:0]       req,
  input  logic [IDX_W*NUM_M-1:0] dst,
  input  logic [NUM_M-1:0]       done,
  output logic [NUM_M-1:0]       gnt,
  output logic [IDX_W*NUM_S-1:0] sel,
  output logic [NUM_S-1:0]       sel_vld,
  output logic                   busy
);

  logic [NUM_M-1:0] cand [NUM_S];
  logic [IDX_W-1:0] sel_d [NUM_S];
  logic [IDX_W-1:0] sel_q [NUM_S];
  logic [NUM_S-1:0] vld_d;
  logic [NUM_S-1:0] vld_q;
  logic [NUM_M-1:0] gnt_q, gnt_d;

  // Candidates: requesting masters aimed at port j that hold no port yet.
  always_comb begin
    for (int j = 0; j < NUM_S; j++) begin
      cand[j] = '0;
      for (int i = 0; i < NUM_M; i++) begin
        cand[j][i] = req[i] & (dst[IDX_W*i +: IDX_W] == IDX_W'(j)) & ~gnt_q[i];
      end
    end
  end

  for (genvar j = 0; j < NUM_S; j++) begin : g_port
    xbar_port_arb #(
      .HOLD_MAX (HOLD_MAX),
      .CNT_W    (CNT_W)
    ) u_port (
      .clk     (clk),
      .reset   (reset),
      .cand_i  (cand[j]),
      .req_i   (req),
      .done_i  (done),
      .sel_d_o (sel_d[j]),
      .vld_d_o (vld_d[j]),
      .sel_q_o (sel_q[j]),
      .vld_q_o (vld_q[j])
    );
  end

  // Next grant vector: OR of the owners every port will have after this edge.
  always_comb begin
    gnt_d = '0;
    for (int j = 0; j < NUM_S; j++) begin
      if (vld_d[j]) gnt_d[sel_d[j]] = 1'b1;
    end
  end

  // Grant register, so gnt never depends combinationally on inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_q <= '0;
    end else begin
      gnt_q <= gnt_d;
    end
  end

  // Pack per-port selects onto the flat output bus.
  always_comb begin
    sel = '0;
    for (int j = 0; j < NUM_S; j++) begin
      sel[IDX_W*j +: IDX_W] = sel_q[j];
    end
  end

  assign gnt     = gnt_q;
  assign sel_vld = vld_q;
  assign busy    = |vld_q;

endmodule
